rs_dispatch_scheduler: RTL and testbench
========================================

Name: rs_dispatch_scheduler

Overview:
Four-entry reservation station with per-unit dispatch scheduler for the Tomasulo datapath. Accepts decoded instructions from issue and snoops the 16-bit CDB to capture pending operands. Dispatches the oldest ready entry to ULA (arithmetic) or ULA_ld_sd (load/store address). Frees an entry when its own result is broadcast on the CDB. The tag it assigns is the RS position carried in cdb[12:11].

Parameters:
ENTRIES, 4, reservation station depth; fixed by the 2-bit tag field cdb[12:11]
DATA_W, 10, operand/data width; matches cdb[9:0]
OP_W, 3, opcode width passed through to the units

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; clears all state
issue_valid  in  1  instruction presented this cycle
issue_ready  out  1  at least one FREE entry; issue accepted when valid&&ready
issue_tag  out  2  tag that an accepted issue will receive (lowest-index FREE entry)
issue_op  in  OP_W  opcode
issue_unit  in  1  1 = ULA, 0 = ULA_ld_sd (same encoding as cdb[10])
issue_dest  in  3  one-hot destination R0/R1/R2 (cdb[15:13] format)
issue_s1_rdy, issue_s2_rdy  in  1 each  operand already valid
issue_s1_val, issue_s2_val  in  DATA_W each  operand value when rdy
issue_s1_tag, issue_s2_tag  in  2 each  producing tag when not rdy
cdb  in  16  broadcast bus; 16'hFFFF = no broadcast
alu_busy, ldsd_busy  in  1 each  unit cannot accept this cycle
alu_valid, ldsd_valid  out  1 each  one-cycle dispatch strobe
alu_op, ldsd_op  out  OP_W each
alu_a, alu_b, ldsd_a, ldsd_b  out  DATA_W each  operands
alu_tag, ldsd_tag  out  2 each  RS tag for cdb[12:11]
alu_dest, ldsd_dest  out  3 each  one-hot destination

Behaviour:
- Reset (sync, high): all entries FREE; age cleared; all valid outputs 0; data outputs 0; issue_ready 1 on the cycle after reset deasserts. Reset mid-operation discards in-flight work. Later CDB broadcasts of discarded tags are ignored because the entries are FREE.
- Per-entry FSM: FREE -> (issue) WAIT if any source not ready, else READY; WAIT -> READY once both sources are captured; READY -> EXEC on dispatch; EXEC -> FREE when cdb != 16'hFFFF && cdb[12:11] == own tag. No other transitions.
- CDB snoop: every WAIT source whose tag equals cdb[12:11] (cdb valid) latches cdb[9:0] at the edge. The entry becomes READY the following cycle and can be dispatched at the earliest on that cycle's edge.
- Issue bypass: if the issuing source tag matches a valid CDB in the same cycle, capture cdb[9:0] directly and mark the source ready.
- Allocation: lowest-index FREE entry. A slot freed by the CDB this cycle is not reusable until the next cycle. Issue with issue_ready=0 is ignored, with no state change.
- Age: a 2-bit rank per entry counts later issues, saturating at 3. Selection per unit picks the ready entry with the highest rank; ties between ranks are impossible.
- Dispatch: at an edge where unit busy=0 and a READY entry for that unit exists, the selected entry moves to EXEC. The output registers load op/a/b/tag/dest, and valid is 1 for exactly the next cycle, then 0.
- Both units may dispatch in the same cycle, one per unit. Busy=1 holds entries READY with no output change.
- An entry being freed and a new dispatch for the same unit in the same cycle are independent.
- Operand arithmetic: none; values pass through unmodified at DATA_W.

Decomposition:
- Shared package: CDB field positions (dest [15:13], tag [12:11], unit [10], data [9:0]), CDB_INVALID = 16'hFFFF, UNIT_ALU = 1 / UNIT_LDSD = 0, entry state encoding (FREE/WAIT/READY/EXEC).
- Sub-module rs_age_select: given per-entry ready mask and ranks, returns one-hot oldest grant plus a valid flag. Instantiated twice, once per unit.

Test Plan:
- Reset, then issue ADD (unit=1, both rdy, a=5, b=7, dest=R1) -> issue_tag=0; next-next cycle alu_valid=1, a=5, b=7, tag=0, dest=3'b010; entry stays EXEC until cdb=16'h400C with tag 0, then FREE.
- Issue I1 tag0 (s1 pending on tag 2) and I2 tag1 (ready, ALU) -> I2 dispatches first. cdb=16'h1015 (tag 2, data 0x015) -> tag0 captures a=0x015 and dispatches one cycle later.
- Issue with s1_tag=3 in the same cycle cdb carries tag 3 data 0x0AA -> entry READY immediately; dispatched operand a=0x0AA.
- Fill 4 entries with alu_busy=1 -> issue_ready=0; 5th issue ignored. Release busy -> dispatch order equals issue order 0,1,2,3.
- One ALU and one LD/SD entry ready, both units idle -> alu_valid and ldsd_valid both pulse in the same cycle with correct tags.
- Assert reset while two entries are EXEC, then broadcast their tags on cdb -> no valid strobes; all entries FREE; issue_ready=1.

Source files
------------

// File: rtl/rs_dispatch_scheduler_pkg.sv
// Shared definitions for the four-entry reservation station: CDB field layout,
// unit encoding and per-entry state.
package rs_dispatch_scheduler_pkg;

  localparam int ENTRIES = 4;
  localparam int DATA_W  = 10;
  localparam int OP_W    = 3;
  localparam int TAG_W   = 2;

  localparam int CDB_DEST_HI = 15;
  localparam int CDB_DEST_LO = 13;
  localparam int CDB_TAG_HI  = 12;
  localparam int CDB_TAG_LO  = 11;
  localparam int CDB_UNIT    = 10;
  localparam int CDB_DATA_HI = 9;

  localparam logic [15:0] CDB_INVALID = 16'hFFFF;
  localparam logic        UNIT_ALU    = 1'b1;
  localparam logic        UNIT_LDSD   = 1'b0;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_EXEC  = 2'd3
  } entry_state_e;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              unit;
    logic [2:0]        dest;
    logic              s1_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_rdy;
    logic [DATA_W-1:0] s2_val;
    logic [TAG_W-1:0]  s2_tag;
  } entry_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-ready picker: grants the ready entry whose rank beats every other
// ready entry; equal ranks fall back to the lower index.
module rs_age_select
  import rs_dispatch_scheduler_pkg::*;
#(
  parameter int N = ENTRIES
) (
  input  logic [N-1:0]            ready,
  input  logic [N-1:0][TAG_W-1:0] rank,
  output logic [N-1:0]            grant,
  output logic                    valid
);

  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    logic [N-1:0] beats;
    for (genvar gj = 0; gj < N; gj++) begin : g_vs
      if (gi == gj) begin : g_self
        assign beats[gj] = 1'b1;
      end else if (gi < gj) begin : g_lo
        assign beats[gj] = !ready[gj] || (rank[gi] >= rank[gj]);
      end else begin : g_hi
        assign beats[gj] = !ready[gj] || (rank[gi] > rank[gj]);
      end
    end
    assign grant[gi] = ready[gi] && (&beats);
  end

  assign valid = |ready;

endmodule

// File: rtl/rs_dispatch_scheduler.sv
// Four-entry reservation station: issue allocation, CDB operand snoop,
// oldest-first dispatch to ALU and load/store units, release on own CDB tag.
module rs_dispatch_scheduler
  import rs_dispatch_scheduler_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic [OP_W-1:0]   issue_op,
  input  logic              issue_unit,
  input  logic [2:0]        issue_dest,
  input  logic              issue_s1_rdy,
  input  logic              issue_s2_rdy,
  input  logic [DATA_W-1:0] issue_s1_val,
  input  logic [DATA_W-1:0] issue_s2_val,
  input  logic [TAG_W-1:0]  issue_s1_tag,
  input  logic [TAG_W-1:0]  issue_s2_tag,
  input  logic [15:0]       cdb,
  input  logic              alu_busy,
  input  logic              ldsd_busy,
  output logic              alu_valid,
  output logic              ldsd_valid,
  output logic [OP_W-1:0]   alu_op,
  output logic [OP_W-1:0]   ldsd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] ldsd_a,
  output logic [DATA_W-1:0] ldsd_b,
  output logic [TAG_W-1:0]  alu_tag,
  output logic [TAG_W-1:0]  ldsd_tag,
  output logic [2:0]        alu_dest,
  output logic [2:0]        ldsd_dest
);

  entry_state_e                state_reg [ENTRIES];
  entry_state_e                state_next[ENTRIES];
  entry_t                      ent_reg   [ENTRIES];
  entry_t                      ent_next  [ENTRIES];
  logic [ENTRIES-1:0][TAG_W-1:0] rank_reg, rank_next;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic [ENTRIES-1:0] free_mask, alu_rdy_mask, ldsd_rdy_mask, alu_grant, ldsd_grant;
  logic alu_sel_valid, ldsd_sel_valid, alu_fire, ldsd_fire, issue_fire, freed_any;
  logic [TAG_W-1:0] freed_rank, alu_sel_tag, ldsd_sel_tag;
  entry_t alu_sel_ent, ldsd_sel_ent;

  assign cdb_valid = (cdb != CDB_INVALID);
  assign cdb_tag   = cdb[CDB_TAG_HI:CDB_TAG_LO];
  assign cdb_data  = cdb[CDB_DATA_HI:0];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_mask
    assign free_mask[gi]     = (state_reg[gi] == ST_FREE);
    assign alu_rdy_mask[gi]  = (state_reg[gi] == ST_READY) && (ent_reg[gi].unit == UNIT_ALU);
    assign ldsd_rdy_mask[gi] = (state_reg[gi] == ST_READY) && (ent_reg[gi].unit == UNIT_LDSD);
  end

  assign issue_ready = |free_mask;
  assign issue_fire  = issue_valid && issue_ready;
  assign freed_any   = cdb_valid && (state_reg[cdb_tag] == ST_EXEC);
  assign freed_rank  = rank_reg[cdb_tag];

  always_comb begin
    issue_tag = '0;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (free_mask[i]) issue_tag = TAG_W'(i);
  end

  rs_age_select #(.N(ENTRIES)) u_alu_sel (
    .ready(alu_rdy_mask), .rank(rank_reg), .grant(alu_grant), .valid(alu_sel_valid)
  );
  rs_age_select #(.N(ENTRIES)) u_ldsd_sel (
    .ready(ldsd_rdy_mask), .rank(rank_reg), .grant(ldsd_grant), .valid(ldsd_sel_valid)
  );

  assign alu_fire  = alu_sel_valid && !alu_busy;
  assign ldsd_fire = ldsd_sel_valid && !ldsd_busy;

  always_comb begin
    alu_sel_ent  = '0;
    alu_sel_tag  = '0;
    ldsd_sel_ent = '0;
    ldsd_sel_tag = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (alu_grant[i]) begin
        alu_sel_ent = ent_reg[i];
        alu_sel_tag = TAG_W'(i);
      end
      if (ldsd_grant[i]) begin
        ldsd_sel_ent = ent_reg[i];
        ldsd_sel_tag = TAG_W'(i);
      end
    end
  end

  // Ranks stay a dense 0..n-1 ordering of live entries: a release shifts down
  // everything older than the released entry, so ranks never collide.
  always_comb begin
    logic [2:0] sum;
    for (int i = 0; i < ENTRIES; i++) begin
      state_next[i] = state_reg[i];
      ent_next[i]   = ent_reg[i];
      rank_next[i]  = rank_reg[i];
      sum           = {1'b0, rank_reg[i]} + {2'b0, issue_fire}
                    - {2'b0, (freed_any && (freed_rank < rank_reg[i]))};
      if (state_reg[i] != ST_FREE) rank_next[i] = (sum > 3'd3) ? 2'd3 : sum[1:0];
      case (state_reg[i])
        ST_FREE: begin
          if (issue_fire && (issue_tag == TAG_W'(i))) begin
            ent_next[i].op     = issue_op;
            ent_next[i].unit   = issue_unit;
            ent_next[i].dest   = issue_dest;
            ent_next[i].s1_tag = issue_s1_tag;
            ent_next[i].s2_tag = issue_s2_tag;
            ent_next[i].s1_rdy = issue_s1_rdy || (cdb_valid && (cdb_tag == issue_s1_tag));
            ent_next[i].s2_rdy = issue_s2_rdy || (cdb_valid && (cdb_tag == issue_s2_tag));
            ent_next[i].s1_val = issue_s1_rdy ? issue_s1_val : cdb_data;
            ent_next[i].s2_val = issue_s2_rdy ? issue_s2_val : cdb_data;
            rank_next[i]       = '0;
            state_next[i] = (ent_next[i].s1_rdy && ent_next[i].s2_rdy) ? ST_READY : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!ent_reg[i].s1_rdy && cdb_valid && (cdb_tag == ent_reg[i].s1_tag)) begin
            ent_next[i].s1_rdy = 1'b1;
            ent_next[i].s1_val = cdb_data;
          end
          if (!ent_reg[i].s2_rdy && cdb_valid && (cdb_tag == ent_reg[i].s2_tag)) begin
            ent_next[i].s2_rdy = 1'b1;
            ent_next[i].s2_val = cdb_data;
          end
          if (ent_next[i].s1_rdy && ent_next[i].s2_rdy) state_next[i] = ST_READY;
        end
        ST_READY: begin
          if ((alu_fire && alu_grant[i]) || (ldsd_fire && ldsd_grant[i]))
            state_next[i] = ST_EXEC;
        end
        ST_EXEC: begin
          if (cdb_valid && (cdb_tag == TAG_W'(i))) state_next[i] = ST_FREE;
        end
        default: state_next[i] = ST_FREE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_reg[i] <= ST_FREE;
        ent_reg[i]   <= '0;
      end
      rank_reg <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_reg[i] <= state_next[i];
        ent_reg[i]   <= ent_next[i];
      end
      rank_reg <= rank_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alu_valid  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_tag    <= '0;
      alu_dest   <= '0;
      ldsd_valid <= 1'b0;
      ldsd_op    <= '0;
      ldsd_a     <= '0;
      ldsd_b     <= '0;
      ldsd_tag   <= '0;
      ldsd_dest  <= '0;
    end else begin
      alu_valid  <= alu_fire;
      ldsd_valid <= ldsd_fire;
      if (alu_fire) begin
        alu_op   <= alu_sel_ent.op;
        alu_a    <= alu_sel_ent.s1_val;
        alu_b    <= alu_sel_ent.s2_val;
        alu_tag  <= alu_sel_tag;
        alu_dest <= alu_sel_ent.dest;
      end
      if (ldsd_fire) begin
        ldsd_op   <= ldsd_sel_ent.op;
        ldsd_a    <= ldsd_sel_ent.s1_val;
        ldsd_b    <= ldsd_sel_ent.s2_val;
        ldsd_tag  <= ldsd_sel_tag;
        ldsd_dest <= ldsd_sel_ent.dest;
      end
    end
  end

endmodule

// File: tb/tb_rs_dispatch_scheduler.sv
// Directed bench for rs_dispatch_scheduler: a per-cycle vector table for the
// single-flow cases, then hand sequences for fill/order, dual dispatch, reset.
module tb_rs_dispatch_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready;
  logic [1:0]  issue_tag;
  logic [2:0]  issue_op;
  logic        issue_unit;
  logic [2:0]  issue_dest;
  logic        issue_s1_rdy, issue_s2_rdy;
  logic [9:0]  issue_s1_val, issue_s2_val;
  logic [1:0]  issue_s1_tag, issue_s2_tag;
  logic [15:0] cdb;
  logic        alu_busy, ldsd_busy, alu_valid, ldsd_valid;
  logic [2:0]  alu_op, ldsd_op, alu_dest, ldsd_dest;
  logic [9:0]  alu_a, alu_b, ldsd_a, ldsd_b;
  logic [1:0]  alu_tag, ldsd_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  rs_dispatch_scheduler dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
    .issue_op(issue_op), .issue_unit(issue_unit), .issue_dest(issue_dest),
    .issue_s1_rdy(issue_s1_rdy), .issue_s2_rdy(issue_s2_rdy),
    .issue_s1_val(issue_s1_val), .issue_s2_val(issue_s2_val),
    .issue_s1_tag(issue_s1_tag), .issue_s2_tag(issue_s2_tag),
    .cdb(cdb), .alu_busy(alu_busy), .ldsd_busy(ldsd_busy),
    .alu_valid(alu_valid), .ldsd_valid(ldsd_valid),
    .alu_op(alu_op), .ldsd_op(ldsd_op),
    .alu_a(alu_a), .alu_b(alu_b), .ldsd_a(ldsd_a), .ldsd_b(ldsd_b),
    .alu_tag(alu_tag), .ldsd_tag(ldsd_tag),
    .alu_dest(alu_dest), .ldsd_dest(ldsd_dest)
  );

  typedef struct {
    logic iv; logic unit; logic [2:0] op; logic [2:0] dest;
    logic s1r; logic [9:0] s1v; logic [1:0] s1t;
    logic s2r; logic [9:0] s2v; logic [1:0] s2t;
    logic [15:0] cdb;
    logic ird; logic [1:0] itag;
    logic av; logic [2:0] aop; logic [9:0] aa, ab; logic [1:0] atag; logic [2:0] adest;
    logic lv; logic [2:0] lop; logic [9:0] la, lb; logic [1:0] ltag; logic [2:0] ldest;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  function automatic vec_t mk_idle(logic [15:0] c, logic [1:0] itag);
    vec_t v;
    v = '{default: '0};
    v.cdb  = c;
    v.ird  = 1'b1;
    v.itag = itag;
    return v;
  endfunction

  function automatic vec_t mk_issue(logic u, logic [2:0] op, logic [2:0] dest,
                                    logic s1r, logic [9:0] s1v, logic [1:0] s1t,
                                    logic s2r, logic [9:0] s2v, logic [1:0] s2t,
                                    logic [15:0] c, logic [1:0] itag);
    vec_t v;
    v = mk_idle(c, itag);
    v.iv = 1'b1; v.unit = u; v.op = op; v.dest = dest;
    v.s1r = s1r; v.s1v = s1v; v.s1t = s1t;
    v.s2r = s2r; v.s2v = s2v; v.s2t = s2t;
    return v;
  endfunction

  function automatic vec_t with_alu(vec_t vin, logic [2:0] op, logic [9:0] a, logic [9:0] b,
                                    logic [1:0] tag, logic [2:0] dest);
    vec_t v;
    v = vin;
    v.av = 1'b1; v.aop = op; v.aa = a; v.ab = b; v.atag = tag; v.adest = dest;
    return v;
  endfunction

  function automatic vec_t with_ldsd(vec_t vin, logic [2:0] op, logic [9:0] a, logic [9:0] b,
                                     logic [1:0] tag, logic [2:0] dest);
    vec_t v;
    v = vin;
    v.lv = 1'b1; v.lop = op; v.la = a; v.lb = b; v.ltag = tag; v.ldest = dest;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle(input logic [15:0] c);
    issue_valid = 1'b0;
    cdb = c;
  endtask

  task automatic drive_issue(input logic u, input logic [2:0] op, input logic [2:0] dest,
                             input logic [9:0] a, input logic [9:0] b);
    issue_valid = 1'b1; issue_unit = u; issue_op = op; issue_dest = dest;
    issue_s1_rdy = 1'b1; issue_s1_val = a; issue_s1_tag = 2'd0;
    issue_s2_rdy = 1'b1; issue_s2_val = b; issue_s2_tag = 2'd0;
    cdb = 16'hFFFF;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle(16'hFFFF);
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; issue_valid = 0; issue_op = 0; issue_unit = 0; issue_dest = 0;
    issue_s1_rdy = 0; issue_s2_rdy = 0; issue_s1_val = 0; issue_s2_val = 0;
    issue_s1_tag = 0; issue_s2_tag = 0; cdb = 16'hFFFF; alu_busy = 0; ldsd_busy = 0;

    vecs[0]  = mk_issue(1, 3'd1, 3'b010, 1, 10'd5, 0, 1, 10'd7, 0, 16'hFFFF, 2'd1);
    vecs[1]  = with_alu(mk_idle(16'hFFFF, 2'd1), 3'd1, 10'd5, 10'd7, 2'd0, 3'b010);
    vecs[2]  = mk_idle(16'hFFFF, 2'd1);
    vecs[3]  = mk_idle(16'h400C, 2'd0);
    vecs[4]  = mk_issue(1, 3'd2, 3'b001, 0, 10'd0, 2'd2, 1, 10'd3, 0, 16'hFFFF, 2'd1);
    vecs[5]  = mk_issue(1, 3'd1, 3'b100, 1, 10'd9, 0, 1, 10'd4, 0, 16'hFFFF, 2'd2);
    vecs[6]  = with_alu(mk_idle(16'hFFFF, 2'd2), 3'd1, 10'd9, 10'd4, 2'd1, 3'b100);
    vecs[7]  = mk_idle(16'h1015, 2'd2);
    vecs[8]  = with_alu(mk_idle(16'hFFFF, 2'd2), 3'd2, 10'h015, 10'd3, 2'd0, 3'b001);
    vecs[9]  = mk_idle(16'h2000, 2'd0);
    vecs[10] = mk_idle(16'h0800, 2'd0);
    vecs[11] = mk_issue(1, 3'd4, 3'b010, 0, 10'd0, 2'd3, 1, 10'd1, 0, 16'h18AA, 2'd1);
    vecs[12] = with_alu(mk_idle(16'hFFFF, 2'd1), 3'd4, 10'h0AA, 10'd1, 2'd0, 3'b010);
    vecs[13] = mk_idle(16'h2000, 2'd0);
    vecs[14] = mk_issue(0, 3'd5, 3'b100, 1, 10'h3FF, 0, 1, 10'h200, 0, 16'hFFFF, 2'd1);
    vecs[15] = with_ldsd(mk_idle(16'hFFFF, 2'd1), 3'd5, 10'h3FF, 10'h200, 2'd0, 3'b100);
    vecs[16] = mk_idle(16'h0000, 2'd0);

    do_reset();
    $display("reset state: ready=%0b tag=%0d alu_v=%0b ldsd_v=%0b", issue_ready, issue_tag, alu_valid, ldsd_valid);
    chk("reset_issue_ready", 16'(issue_ready), 16'd1);
    chk("reset_issue_tag", 16'(issue_tag), 16'd0);
    chk("reset_alu_valid", 16'(alu_valid), 16'd0);
    chk("reset_ldsd_valid", 16'(ldsd_valid), 16'd0);
    chk("reset_alu_a", 16'(alu_a), 16'd0);

    for (int i = 0; i < NV; i++) begin
      issue_valid = vecs[i].iv; issue_unit = vecs[i].unit; issue_op = vecs[i].op;
      issue_dest = vecs[i].dest;
      issue_s1_rdy = vecs[i].s1r; issue_s1_val = vecs[i].s1v; issue_s1_tag = vecs[i].s1t;
      issue_s2_rdy = vecs[i].s2r; issue_s2_val = vecs[i].s2v; issue_s2_tag = vecs[i].s2t;
      cdb = vecs[i].cdb;
      step();
      $display("vec %0d: cdb=%h ready=%0b tag=%0d alu_v=%0b a=%h b=%h t=%0d ldsd_v=%0b t=%0d",
               i, vecs[i].cdb, issue_ready, issue_tag, alu_valid, alu_a, alu_b, alu_tag,
               ldsd_valid, ldsd_tag);
      chk($sformatf("v%0d_issue_ready", i), 16'(issue_ready), 16'(vecs[i].ird));
      chk($sformatf("v%0d_issue_tag", i), 16'(issue_tag), 16'(vecs[i].itag));
      chk($sformatf("v%0d_alu_valid", i), 16'(alu_valid), 16'(vecs[i].av));
      chk($sformatf("v%0d_ldsd_valid", i), 16'(ldsd_valid), 16'(vecs[i].lv));
      if (vecs[i].av) begin
        chk($sformatf("v%0d_alu_op", i), 16'(alu_op), 16'(vecs[i].aop));
        chk($sformatf("v%0d_alu_a", i), 16'(alu_a), 16'(vecs[i].aa));
        chk($sformatf("v%0d_alu_b", i), 16'(alu_b), 16'(vecs[i].ab));
        chk($sformatf("v%0d_alu_tag", i), 16'(alu_tag), 16'(vecs[i].atag));
        chk($sformatf("v%0d_alu_dest", i), 16'(alu_dest), 16'(vecs[i].adest));
      end
      if (vecs[i].lv) begin
        chk($sformatf("v%0d_ldsd_op", i), 16'(ldsd_op), 16'(vecs[i].lop));
        chk($sformatf("v%0d_ldsd_a", i), 16'(ldsd_a), 16'(vecs[i].la));
        chk($sformatf("v%0d_ldsd_b", i), 16'(ldsd_b), 16'(vecs[i].lb));
        chk($sformatf("v%0d_ldsd_tag", i), 16'(ldsd_tag), 16'(vecs[i].ltag));
        chk($sformatf("v%0d_ldsd_dest", i), 16'(ldsd_dest), 16'(vecs[i].ldest));
      end
    end

    // Fill all four entries while the ALU is busy, then drain in issue order.
    do_reset();
    alu_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("fill%0d_issue_tag", k), 16'(issue_tag), 16'(k));
      drive_issue(1'b1, 3'(k), 3'b001, 10'(k + 1), 10'd0);
      step();
      $display("fill %0d: ready=%0b alu_v=%0b", k, issue_ready, alu_valid);
    end
    chk("full_issue_ready", 16'(issue_ready), 16'd0);
    drive_issue(1'b1, 3'd7, 3'b100, 10'h03E, 10'h03E);
    step();
    $display("fifth issue: ready=%0b alu_v=%0b", issue_ready, alu_valid);
    chk("fifth_issue_ready", 16'(issue_ready), 16'd0);
    chk("busy_hold_alu_valid", 16'(alu_valid), 16'd0);
    drive_idle(16'hFFFF);
    alu_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      $display("drain %0d: alu_v=%0b tag=%0d a=%h", k, alu_valid, alu_tag, alu_a);
      chk($sformatf("drain%0d_alu_valid", k), 16'(alu_valid), 16'd1);
      chk($sformatf("drain%0d_alu_tag", k), 16'(alu_tag), 16'(k));
      chk($sformatf("drain%0d_alu_a", k), 16'(alu_a), 16'(k + 1));
    end
    step();
    $display("drain done: alu_v=%0b", alu_valid);
    chk("drain_end_alu_valid", 16'(alu_valid), 16'd0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kt;
      kt = 2'(k);
      drive_idle({3'b001, kt, 1'b1, 10'h000});
      step();
      $display("release tag %0d: ready=%0b", k, issue_ready);
    end
    drive_idle(16'hFFFF);
    chk("released_issue_ready", 16'(issue_ready), 16'd1);
    chk("released_issue_tag", 16'(issue_tag), 16'd0);

    // One ALU and one LD/SD entry released together.
    alu_busy = 1'b1;
    ldsd_busy = 1'b1;
    drive_issue(1'b1, 3'd6, 3'b010, 10'h011, 10'h022);
    step();
    drive_issue(1'b0, 3'd7, 3'b100, 10'h033, 10'h044);
    step();
    drive_idle(16'hFFFF);
    step();
    $display("dual held: alu_v=%0b ldsd_v=%0b", alu_valid, ldsd_valid);
    chk("dual_hold_alu_valid", 16'(alu_valid), 16'd0);
    chk("dual_hold_ldsd_valid", 16'(ldsd_valid), 16'd0);
    alu_busy = 1'b0;
    ldsd_busy = 1'b0;
    step();
    $display("dual fire: alu_v=%0b t=%0d a=%h ldsd_v=%0b t=%0d a=%h",
             alu_valid, alu_tag, alu_a, ldsd_valid, ldsd_tag, ldsd_a);
    chk("dual_alu_valid", 16'(alu_valid), 16'd1);
    chk("dual_alu_tag", 16'(alu_tag), 16'd0);
    chk("dual_alu_a", 16'(alu_a), 16'h011);
    chk("dual_ldsd_valid", 16'(ldsd_valid), 16'd1);
    chk("dual_ldsd_tag", 16'(ldsd_tag), 16'd1);
    chk("dual_ldsd_b", 16'(ldsd_b), 16'h044);
    step();
    chk("dual_pulse_alu_valid", 16'(alu_valid), 16'd0);
    chk("dual_pulse_ldsd_valid", 16'(ldsd_valid), 16'd0);

    // Reset with both entries executing; their late broadcasts must be ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    $display("post reset: ready=%0b tag=%0d alu_a=%h ldsd_a=%h", issue_ready, issue_tag, alu_a, ldsd_a);
    chk("mid_reset_alu_a", 16'(alu_a), 16'd0);
    chk("mid_reset_ldsd_a", 16'(ldsd_a), 16'd0);
    drive_idle(16'h2000);
    step();
    drive_idle(16'h8800);
    step();
    drive_idle(16'hFFFF);
    $display("stale cdb: ready=%0b tag=%0d alu_v=%0b ldsd_v=%0b", issue_ready, issue_tag, alu_valid, ldsd_valid);
    chk("stale_alu_valid", 16'(alu_valid), 16'd0);
    chk("stale_ldsd_valid", 16'(ldsd_valid), 16'd0);
    chk("stale_issue_ready", 16'(issue_ready), 16'd1);
    chk("stale_issue_tag", 16'(issue_tag), 16'd0);
    drive_issue(1'b1, 3'd3, 3'b001, 10'h055, 10'h066);
    step();
    drive_idle(16'hFFFF);
    step();
    $display("after reset issue: alu_v=%0b t=%0d a=%h", alu_valid, alu_tag, alu_a);
    chk("after_reset_alu_valid", 16'(alu_valid), 16'd1);
    chk("after_reset_alu_tag", 16'(alu_tag), 16'd0);
    chk("after_reset_alu_a", 16'(alu_a), 16'h055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
